scalar_bank_arb: RTL and testbench

//  Request front-end that sits directly upstream of scalar_bank and feeds its two ports.

---
 rtl/xmem_param_pkg.sv | 6 +
 rtl/scalar_bank_arb_if.sv | 30 +++
 rtl/scalar_bank_arb.sv | 122 ++++++++++++
 tb/tb_scalar_bank_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xmem_param_pkg.sv
// Shared memory-system parameters for the scalar bank path.
// Holds the byte-address width used by the bank and its front-end.
// Compile-time constants only.
package xmem_param_pkg;
  parameter int XMEM_AW = 12;
endpackage

// File: rtl/scalar_bank_arb_if.sv
// Requester-side bundle of scalar_bank_arb: per-requester request and response lanes.
// Requests are combinationally handshaken (valid/ready); responses arrive 1 cycle later.
// Responses carry no ready: a requester must always accept its read data.
interface scalar_bank_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 32
) ();
  import xmem_param_pkg::*;

  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0]                 req_ready;
  logic [NREQ-1:0]                 req_we;
  logic [NREQ-1:0][1:0]            req_len;
  logic [NREQ-1:0][XMEM_AW-1:0]    req_adr;
  logic [NREQ-1:0][DW-1:0]         req_din;
  logic [NREQ-1:0]                 rsp_valid;
  logic [NREQ-1:0][DW-1:0]         rsp_dout;

  // Requesters drive requests and consume grants/responses.
  modport master (
    output req_valid, req_we, req_len, req_adr, req_din,
    input  req_ready, rsp_valid, rsp_dout
  );

  // The arbiter consumes requests and drives grants/responses.
  modport slave (
    input  req_valid, req_we, req_len, req_adr, req_din,
    output req_ready, rsp_valid, rsp_dout
  );
endinterface

// File: rtl/scalar_bank_arb.sv
// Round-robin front-end mapping NREQ scalar requesters onto the two scalar_bank ports.
// Grant is combinational; read data returns to its requester 1 cycle after acceptance.
// Ungranted requesters see req_ready=0 and retry; no response backpressure.
// Optional SCALAR_ARB_SAME_WORD_EN: withhold the port1 grant on a same-word pair involving a write.
module scalar_bank_arb
  import xmem_param_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               rstn,
  scalar_bank_arb_if.slave   req,
  output logic               we0,
  output logic               we1,
  output logic [1:0]         len0,
  output logic [1:0]         len1,
  output logic [XMEM_AW-1:0] adr0,
  output logic [XMEM_AW-1:0] adr1,
  output logic [DW-1:0]      din0,
  output logic [DW-1:0]      din1,
  input  logic [DW-1:0]      dout0,
  input  logic [DW-1:0]      dout1
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_nxt;
  logic          rd_v0, rd_v1;
  logic [PW-1:0] rd_idx0, rd_idx1;

  logic          g0_v, g1_v;
  logic [PW-1:0] g0_i, g1_i;
  logic [PW-1:0] last_i;

  // Scan from rr_ptr with wrap: first valid requester takes port0, second takes port1.
  always_comb begin
    int idx;
    g0_v = 1'b0;
    g0_i = '0;
    g1_v = 1'b0;
    g1_i = '0;
    idx  = 0;
    if (rstn) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (req.req_valid[idx]) begin
          if (!g0_v) begin
            g0_v = 1'b1;
            g0_i = PW'(idx);
          end else if (!g1_v) begin
            g1_v = 1'b1;
            g1_i = PW'(idx);
          end
        end
      end
`ifdef SCALAR_ARB_SAME_WORD_EN
      // A write sharing a word with the other port is serialised: port1 retries later.
      if (g1_v &&
          (req.req_adr[g0_i][XMEM_AW-1:2] == req.req_adr[g1_i][XMEM_AW-1:2]) &&
          (req.req_we[g0_i] || req.req_we[g1_i])) begin
        g1_v = 1'b0;
      end
`endif
    end
  end

  // Pointer moves just past the last requester actually granted this cycle.
  always_comb begin
    last_i = g1_v ? g1_i : g0_i;
    rr_nxt = (last_i == PW'(NREQ - 1)) ? '0 : last_i + PW'(1);
  end

  // Ready lanes and bank port drive; idle ports are driven to all-zero.
  always_comb begin
    req.req_ready = '0;
    if (g0_v) req.req_ready[g0_i] = 1'b1;
    if (g1_v) req.req_ready[g1_i] = 1'b1;
    we0  = g0_v & req.req_we[g0_i];
    len0 = g0_v ? req.req_len[g0_i] : 2'b00;
    adr0 = g0_v ? req.req_adr[g0_i] : '0;
    din0 = g0_v ? req.req_din[g0_i] : '0;
    we1  = g1_v & req.req_we[g1_i];
    len1 = g1_v ? req.req_len[g1_i] : 2'b00;
    adr1 = g1_v ? req.req_adr[g1_i] : '0;
    din1 = g1_v ? req.req_din[g1_i] : '0;
  end

  // Round-robin pointer and per-port one-stage read return pipe.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr  <= '0;
      rd_v0   <= 1'b0;
      rd_v1   <= 1'b0;
      rd_idx0 <= '0;
      rd_idx1 <= '0;
    end else begin
      if (g0_v) rr_ptr <= rr_nxt;
      rd_v0   <= g0_v & ~req.req_we[g0_i];
      rd_v1   <= g1_v & ~req.req_we[g1_i];
      rd_idx0 <= g0_i;
      rd_idx1 <= g1_i;
    end
  end

  // Steer bank read data to its issuing lane; gated by rstn so in-flight reads drop on reset.
  always_comb begin
    req.rsp_valid = '0;
    req.rsp_dout  = '0;
    if (rstn && rd_v0) begin
      req.rsp_valid[rd_idx0] = 1'b1;
      req.rsp_dout[rd_idx0]  = dout0;
    end
    if (rstn && rd_v1) begin
      req.rsp_valid[rd_idx1] = 1'b1;
      req.rsp_dout[rd_idx1]  = dout1;
    end
  end

endmodule

// File: tb/tb_scalar_bank_arb.sv
// Bench for scalar_bank_arb: directed vector table plus hand-written corner sequences.
// Includes a byte-addressed behavioural bank (reads return pre-write data, 1-cycle latency).
// Honors SCALAR_ARB_SAME_WORD_EN for the same-word sequence.
module tb_scalar_bank_arb;
  import xmem_param_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic clk = 1'b0;
  logic rstn;
  logic we0, we1;
  logic [1:0] len0, len1;
  logic [XMEM_AW-1:0] adr0, adr1;
  logic [DW-1:0] din0, din1, dout0, dout1;

  int checks = 0;
  int failures = 0;

  scalar_bank_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  scalar_bank_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .req(bus),
    .we0(we0), .we1(we1), .len0(len0), .len1(len1),
    .adr0(adr0), .adr1(adr1), .din0(din0), .din1(din1),
    .dout0(dout0), .dout1(dout1)
  );

  always #5 clk = ~clk;

  // Behavioural bank
  logic [7:0] mem [0:(1<<XMEM_AW)-1];

  function automatic logic [31:0] bank_rd(input logic [XMEM_AW-1:0] a, input logic [1:0] l);
    logic [31:0] w;
    w = {mem[a + XMEM_AW'(3)], mem[a + XMEM_AW'(2)], mem[a + XMEM_AW'(1)], mem[a]};
    case (l)
      2'd0:    return {24'h0, w[7:0]};
      2'd1:    return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic int nbytes(input logic [1:0] l);
    return (l == 2'd0) ? 1 : (l == 2'd1) ? 2 : 4;
  endfunction

  always @(posedge clk) begin
    dout0 <= bank_rd(adr0, len0);
    dout1 <= bank_rd(adr1, len1);
    for (int b = 0; b < 4; b++) begin
      if (we0 && b < nbytes(len0)) mem[adr0 + XMEM_AW'(b)] <= din0[8*b +: 8];
      if (we1 && b < nbytes(len1)) mem[adr1 + XMEM_AW'(b)] <= din1[8*b +: 8];
    end
  end

  // Alignment guard on accepted requests
  always @(posedge clk) begin
    if (rstn === 1'b1) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i] &&
            ((bus.req_len[i] == 2'd1 && bus.req_adr[i][0]) ||
             (bus.req_len[i] == 2'd3 && bus.req_adr[i][1:0] != 2'b00))) begin
          failures++;
          $display("FAIL align req%0d adr=%h len=%0d", i, bus.req_adr[i], bus.req_len[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]         valid;
    logic [3:0]         we;
    logic [3:0]         exp_ready;
    logic [3:0]         exp_rsp;
    logic               exp_we0;
    logic               exp_we1;
    logic [XMEM_AW-1:0] exp_adr0;
    logic [XMEM_AW-1:0] exp_adr1;
  } vec_t;

  vec_t tbl [9];

  initial begin
    for (int a = 0; a < (1 << XMEM_AW); a++) mem[a] = 8'h00;

    // Requester i sits at word address i*0x10 for the table.
    tbl[0] = '{4'b1111, 4'b0000, 4'b0011, 4'b0000, 1'b0, 1'b0, 12'h000, 12'h010};
    tbl[1] = '{4'b1111, 4'b0000, 4'b1100, 4'b0011, 1'b0, 1'b0, 12'h020, 12'h030};
    tbl[2] = '{4'b1111, 4'b0000, 4'b0011, 4'b1100, 1'b0, 1'b0, 12'h000, 12'h010};
    tbl[3] = '{4'b1111, 4'b0000, 4'b1100, 4'b0011, 1'b0, 1'b0, 12'h020, 12'h030};
    tbl[4] = '{4'b0100, 4'b0100, 4'b0100, 4'b1100, 1'b1, 1'b0, 12'h020, 12'h000};
    tbl[5] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 12'h000, 12'h000};
    tbl[6] = '{4'b1001, 4'b0000, 4'b1001, 4'b0001, 1'b0, 1'b0, 12'h030, 12'h000};
    tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b1001, 1'b0, 1'b0, 12'h000, 12'h000};
    tbl[8] = '{4'b0011, 4'b0010, 4'b0011, 4'b0000, 1'b1, 1'b0, 12'h010, 12'h000};

    rstn = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_we    = 4'b0000;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_len[i] = 2'd3;
      bus.req_adr[i] = XMEM_AW'(i * 16);
      bus.req_din[i] = 32'hA0 + 32'(i);
    end

    // Reset held 3 cycles with every requester asking
    for (int c = 0; c < 3; c++) begin
      tick();
      #3;
      chk("rst_ready", 128'(bus.req_ready), 128'(0));
      chk("rst_we", 128'({we0, we1}), 128'(0));
      chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
      chk("rst_rsp_dout", 128'(bus.rsp_dout), 128'(0));
    end

    // Vector table: fairness and grant patterns from reset
    for (int r = 0; r < 9; r++) begin
      tick();
      rstn = 1'b1;
      bus.req_valid = tbl[r].valid;
      bus.req_we    = tbl[r].we;
      #3;
      chk($sformatf("tbl%0d_ready", r), 128'(bus.req_ready), 128'(tbl[r].exp_ready));
      chk($sformatf("tbl%0d_rsp", r), 128'(bus.rsp_valid), 128'(tbl[r].exp_rsp));
      chk($sformatf("tbl%0d_we", r), 128'({we0, we1}), 128'({tbl[r].exp_we0, tbl[r].exp_we1}));
      chk($sformatf("tbl%0d_adr", r), 128'({adr0, adr1}), 128'({tbl[r].exp_adr0, tbl[r].exp_adr1}));
    end

    // Single requester word write then read back
    tick();
    bus.req_valid = 4'b0010; bus.req_we = 4'b0010;
    bus.req_len[1] = 2'd3; bus.req_adr[1] = 12'h040; bus.req_din[1] = 32'hDEADBEEF;
    #3;
    chk("single_wr_ready", 128'(bus.req_ready), 128'(4'b0010));
    chk("single_wr_port", 128'({we0, we1, adr0, din0}), 128'({1'b1, 1'b0, 12'h040, 32'hDEADBEEF}));
    tick();
    bus.req_we = 4'b0000;
    #3;
    chk("single_rd_ready", 128'(bus.req_ready), 128'(4'b0010));
    chk("single_rd_we0", 128'(we0), 128'(0));
    tick();
    bus.req_valid = 4'b0000;
    #3;
    chk("single_rsp_valid", 128'(bus.rsp_valid), 128'(4'b0010));
    chk("single_rsp_dout", 128'(bus.rsp_dout), 128'(32'hDEADBEEF) << 32);

    // Byte and half reads of a written word; back-to-back issue on return cycle
    tick();
    bus.req_valid = 4'b0100; bus.req_we = 4'b0100;
    bus.req_len[2] = 2'd3; bus.req_adr[2] = 12'h080; bus.req_din[2] = 32'h11223344;
    #3;
    chk("bh_wr_ready", 128'(bus.req_ready), 128'(4'b0100));
    tick();
    bus.req_we = 4'b0000; bus.req_len[2] = 2'd0; bus.req_adr[2] = 12'h082;
    #3;
    chk("bh_byte_port", 128'({len0, adr0}), 128'({2'd0, 12'h082}));
    tick();
    bus.req_len[2] = 2'd1;
    #3;
    chk("bh_byte_rsp_valid", 128'(bus.rsp_valid), 128'(4'b0100));
    chk("bh_byte_dout", 128'(bus.rsp_dout), 128'(32'h22) << 64);
    chk("bh_reissue_ready", 128'(bus.req_ready), 128'(4'b0100));
    tick();
    bus.req_valid = 4'b0000;
    #3;
    chk("bh_half_dout", 128'(bus.rsp_dout), 128'(32'h1122) << 64);

    // Same-word write/read pair; preload via req3 so rr_ptr wraps to 0
    tick();
    bus.req_valid = 4'b1000; bus.req_we = 4'b1000;
    bus.req_len[3] = 2'd3; bus.req_adr[3] = 12'h100; bus.req_din[3] = 32'hAABBCCDD;
    #3;
    chk("sw_pre_ready", 128'(bus.req_ready), 128'(4'b1000));
    tick();
    bus.req_valid = 4'b0011; bus.req_we = 4'b0001;
    bus.req_len[0] = 2'd3; bus.req_adr[0] = 12'h100; bus.req_din[0] = 32'h55667788;
    bus.req_len[1] = 2'd1; bus.req_adr[1] = 12'h102;
    #3;
`ifdef SCALAR_ARB_SAME_WORD_EN
    chk("sw_ready", 128'(bus.req_ready), 128'(4'b0001));
    chk("sw_port1_idle", 128'({we1, adr1}), 128'(0));
    tick();
    bus.req_valid = 4'b0010; bus.req_we = 4'b0000;
    #3;
    chk("sw_retry_ready", 128'(bus.req_ready), 128'(4'b0010));
    chk("sw_retry_adr0", 128'(adr0), 128'(12'h102));
    tick();
    bus.req_valid = 4'b0000;
    #3;
    chk("sw_rsp_valid", 128'(bus.rsp_valid), 128'(4'b0010));
    chk("sw_rsp_dout", 128'(bus.rsp_dout), 128'(32'h5566) << 32);
`else
    chk("sw_ready", 128'(bus.req_ready), 128'(4'b0011));
    chk("sw_ports", 128'({we0, we1, adr1}), 128'({1'b1, 1'b0, 12'h102}));
    tick();
    bus.req_valid = 4'b0000; bus.req_we = 4'b0000;
    #3;
    chk("sw_rsp_valid", 128'(bus.rsp_valid), 128'(4'b0010));
    chk("sw_rsp_dout", 128'(bus.rsp_dout), 128'(32'hAABB) << 32);
`endif

    // Reset arriving while a read is in flight
    tick();
    bus.req_valid = 4'b0100; bus.req_we = 4'b0000;
    bus.req_len[2] = 2'd3; bus.req_adr[2] = 12'h080;
    #3;
    chk("mid_ready", 128'(bus.req_ready), 128'(4'b0100));
    tick();
    rstn = 1'b0; bus.req_valid = 4'b0000;
    #3;
    chk("mid_rsp_drop", 128'(bus.rsp_valid), 128'(0));
    tick();
    #3;
    chk("mid_rsp_drop2", 128'(bus.rsp_valid), 128'(0));
    tick();
    rstn = 1'b1; bus.req_valid = 4'b1111;
    #3;
    chk("mid_rr_zero", 128'(bus.req_ready), 128'(4'b0011));
    chk("mid_rsp_quiet", 128'(bus.rsp_valid), 128'(0));
    tick();
    bus.req_valid = 4'b0000;
    #3;
    chk("mid_rsp_after", 128'(bus.rsp_valid), 128'(4'b0011));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
